// File: rtl/mac_array_acc_pkg.sv
// mac_array_acc_pkg: shared widths, layer states, lane counts and rescale/saturate (MAC_RELU_EN adds ReLU)
package mac_array_acc_pkg;
  localparam int MAC_NUM = 120;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W = 40;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [6:0] NACT_CONV_1 = 7'd112;
  localparam logic [6:0] NACT_CONV_2 = 7'd100;
  localparam logic [6:0] NACT_FC_1 = 7'd120;
  localparam logic [6:0] NACT_FC_2 = 7'd84;
  localparam logic signed [ACC_W-1:0] SMAX = 40'sd32767;
  localparam logic signed [ACC_W-1:0] SMIN = -40'sd32768;
  typedef enum logic [3:0] {
    SIDLE = 4'd0,
    SCONV_1 = 4'd1,
    SCONV_2 = 4'd2,
    SFC_1 = 4'd3,
    SFC_2 = 4'd4,
    SFC_3 = 4'd5
  } state_t;
  function automatic logic signed [PROD_W-1:0] mul(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b);
    return a * b;
  endfunction
  function automatic logic signed [ACC_W-1:0] sx(input logic signed [PROD_W-1:0] p);
    return p;
  endfunction
  function automatic logic [DATA_W-1:0] rescale(input logic signed [ACC_W-1:0] acc, input logic signed [DATA_W-1:0] b);
    logic signed [ACC_W-1:0] be;
    logic signed [ACC_W-1:0] s;
    logic [DATA_W-1:0] r;
    be = b;
    s = (acc + (be <<< FRAC_W)) >>> FRAC_W;
    r = s > SMAX ? 16'h7fff : s < SMIN ? 16'h8000 : s[DATA_W-1:0];
`ifdef MAC_RELU_EN
    return r[DATA_W-1] ? '0 : r;
`else
    return r;
`endif
  endfunction
endpackage

// File: rtl/mac_array_acc_tree.sv
// mac_adder_tree: registered signed sum of N packed W-bit lanes into OW bits
module mac_adder_tree #(
  parameter int N = 120,
  parameter int W = 32,
  parameter int OW = 40
) (
  input logic clk,
  input logic rst,
  input logic [N*W-1:0] lanes,
  output logic [OW-1:0] sum
);
  logic [OW-1:0] s;
  always_comb begin
    s = '0;
    for (int i = 0; i < N; i++)
      s = s + {{(OW-W){lanes[i*W+W-1]}}, lanes[i*W +: W]};
  end
  always_ff @(posedge clk)
    sum <= rst ? '0 : s;
endmodule

// File: rtl/mac_array_acc.sv
// mac_array_acc: conv/FC MAC array with accumulate, bias, rescale and 16-bit saturation (MAC_RELU_EN adds ReLU)
module mac_array_acc
  import mac_array_acc_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic [3:0] cur_state,
  input logic in_valid,
  input logic first_tap,
  input logic last_tap,
  input logic [MAC_NUM*DATA_W-1:0] input_buf,
  input logic [DATA_W-1:0] weight_bcast,
  input logic [MAC_NUM*DATA_W-1:0] weight_vec,
  input logic [DATA_W-1:0] bias,
  output logic out_valid,
  output logic [MAC_NUM*DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] fc_out
);
  logic st_ok, st_fc, act, fc_r, fc, take;
  logic [6:0] st_n, n_r, n, p_n, a_n;
  logic p_v, p_first, p_last, p_fc, a_v, t_v, t_first, t_last, fa_v;
  logic [MAC_NUM*PROD_W-1:0] prod;
  logic [MAC_NUM*ACC_W-1:0] acc;
  logic [ACC_W-1:0] t_sum, fc_acc;
  assign st_ok = cur_state inside {SCONV_1, SCONV_2, SFC_1, SFC_2, SFC_3};
  assign st_fc = cur_state inside {SFC_1, SFC_2, SFC_3};
  assign st_n = cur_state == SCONV_1 ? NACT_CONV_1 : cur_state == SCONV_2 ? NACT_CONV_2 : cur_state == SFC_1 ? NACT_FC_1 : NACT_FC_2;
  assign take = in_valid & (first_tap ? st_ok : act);
  assign fc = first_tap ? st_fc : fc_r;
  assign n = first_tap ? st_n : n_r;
  always_ff @(posedge clk)
    if (rst) begin
      {act, fc_r, n_r} <= '0;
    end else if (take) begin
      act <= ~last_tap;
      fc_r <= fc;
      n_r <= n;
    end
  always_ff @(posedge clk)
    if (rst) begin
      {p_v, p_first, p_last, p_fc, p_n, prod} <= '0;
    end else begin
      {p_v, p_first, p_last, p_fc, p_n} <= {take, first_tap, last_tap, fc, n};
      for (int i = 0; i < MAC_NUM; i++)
        prod[i*PROD_W +: PROD_W] <= 7'(i) < n ? mul(input_buf[i*DATA_W +: DATA_W], fc ? weight_vec[i*DATA_W +: DATA_W] : weight_bcast) : '0;
    end
  always_ff @(posedge clk)
    if (rst) begin
      {a_v, a_n, acc} <= '0;
    end else begin
      a_v <= p_v & ~p_fc & p_last;
      a_n <= p_n;
      if (p_v & ~p_fc)
        for (int i = 0; i < MAC_NUM; i++)
          acc[i*ACC_W +: ACC_W] <= p_first ? sx(prod[i*PROD_W +: PROD_W]) : acc[i*ACC_W +: ACC_W] + sx(prod[i*PROD_W +: PROD_W]);
    end
  mac_adder_tree #(.N(MAC_NUM), .W(PROD_W), .OW(ACC_W)) u_tree (
    .clk(clk),
    .rst(rst),
    .lanes(prod),
    .sum(t_sum)
  );
  always_ff @(posedge clk)
    if (rst) begin
      {t_v, t_first, t_last, fa_v, fc_acc} <= '0;
    end else begin
      {t_v, t_first, t_last} <= {p_v & p_fc, p_first, p_last};
      fa_v <= t_v & t_last;
      if (t_v)
        fc_acc <= t_first ? t_sum : fc_acc + t_sum;
    end
  always_ff @(posedge clk)
    if (rst) begin
      {out_valid, out_data, fc_out} <= '0;
    end else begin
      out_valid <= a_v | fa_v;
      if (a_v)
        for (int i = 0; i < MAC_NUM; i++)
          out_data[i*DATA_W +: DATA_W] <= 7'(i) < a_n ? rescale(acc[i*ACC_W +: ACC_W], bias) : '0;
      if (fa_v)
        fc_out <= rescale(fc_acc, bias);
    end
endmodule

// File: tb/tb_mac_array_acc.sv
// tb_mac_array_acc: directed self-checking bench for mac_array_acc
module tb_mac_array_acc;
  import mac_array_acc_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] cur_state;
  logic in_valid, first_tap, last_tap, out_valid;
  logic [MAC_NUM*DATA_W-1:0] input_buf, weight_vec, out_data;
  logic [DATA_W-1:0] weight_bcast, bias, fc_out;
  logic [15:0] rq[$];
  logic [15:0] neg_exp;
  int tests = 0;
  int fails = 0;
  int nv = 0;
  int nv0;
  int lat;
  always #5 clk = ~clk;
  always @(negedge clk)
    if (out_valid) begin
      nv++;
      rq.push_back(out_data[15:0]);
    end
  mac_array_acc dut (
    .clk(clk),
    .rst(rst),
    .cur_state(cur_state),
    .in_valid(in_valid),
    .first_tap(first_tap),
    .last_tap(last_tap),
    .input_buf(input_buf),
    .weight_bcast(weight_bcast),
    .weight_vec(weight_vec),
    .bias(bias),
    .out_valid(out_valid),
    .out_data(out_data),
    .fc_out(fc_out)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic fill(input logic [15:0] a, input logic [15:0] w);
    for (int i = 0; i < MAC_NUM; i++) begin
      input_buf[i*16 +: 16] = a;
      weight_vec[i*16 +: 16] = w;
    end
    weight_bcast = w;
  endtask
  task automatic tap(input logic v, input logic f, input logic l);
    in_valid = v;
    first_tap = f;
    last_tap = l;
    @(posedge clk);
    #1;
    in_valid = 0;
    first_tap = 0;
    last_tap = 0;
  endtask
  task automatic window(input int n);
    for (int t = 1; t <= n; t++) tap(1'b1, t == 1, t == n);
  endtask
  task automatic wait_out(output int l);
    l = 1;
    while (!out_valid && l < 20) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [15:0] lane(input int i);
    return out_data[i*16 +: 16];
  endfunction
  initial begin
`ifdef MAC_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hff00;
`endif
    rst = 1;
    cur_state = SIDLE;
    {in_valid, first_tap, last_tap} = '0;
    fill(16'h0000, 16'h0000);
    bias = 16'h0000;
    step(3);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_data_zero", {31'b0, out_data == '0}, 32'd1);
    check("rst_fc", {16'b0, fc_out}, 32'd0);
    rst = 0;
    cur_state = SCONV_1;
    fill(16'h0100, 16'h0100);
    window(25);
    wait_out(lat);
    check("conv1_lat", lat, 32'd3);
    check("conv1_lane0", {16'b0, lane(0)}, 32'h1900);
    check("conv1_lane111", {16'b0, lane(111)}, 32'h1900);
    check("conv1_lane112", {16'b0, lane(112)}, 32'h0000);
    check("conv1_lane119", {16'b0, lane(119)}, 32'h0000);
    step(1);
    check("conv1_strobe_one", {31'b0, out_valid}, 32'd0);
    check("conv1_hold", {16'b0, lane(0)}, 32'h1900);
    cur_state = SCONV_2;
    fill(16'h7fff, 16'h7fff);
    window(25);
    wait_out(lat);
    check("conv2_lat", lat, 32'd3);
    check("conv2_lane0_sat", {16'b0, lane(0)}, 32'h7fff);
    check("conv2_lane99_sat", {16'b0, lane(99)}, 32'h7fff);
    check("conv2_lane100", {16'b0, lane(100)}, 32'h0000);
    check("conv2_fc_held", {16'b0, fc_out}, 32'h0000);
    cur_state = SFC_2;
    fill(16'h0100, 16'h0080);
    bias = 16'h0100;
    tap(1'b1, 1'b1, 1'b1);
    wait_out(lat);
    check("fc2_lat", lat, 32'd4);
    check("fc2_out", {16'b0, fc_out}, 32'h2b00);
    check("fc2_data_held", {16'b0, lane(0)}, 32'h7fff);
    cur_state = SCONV_1;
    bias = 16'h0000;
    fill(16'hff00, 16'h0100);
    tap(1'b1, 1'b1, 1'b1);
    wait_out(lat);
    check("neg_lat", lat, 32'd3);
    check("neg_lane0", {16'b0, lane(0)}, {16'b0, neg_exp});
    check("neg_lane111", {16'b0, lane(111)}, {16'b0, neg_exp});
    step(2);
    fill(16'h0100, 16'h0100);
    nv0 = nv;
    for (int t = 1; t <= 9; t++) tap(1'b1, t == 1, 1'b0);
    rst = 1;
    tap(1'b1, 1'b0, 1'b0);
    rst = 0;
    for (int t = 11; t <= 25; t++) tap(1'b1, 1'b0, t == 25);
    step(8);
    check("abort_no_out", nv - nv0, 32'd0);
    check("abort_data_cleared", {16'b0, lane(0)}, 32'h0000);
    window(25);
    wait_out(lat);
    check("fresh_lat", lat, 32'd3);
    check("fresh_lane0", {16'b0, lane(0)}, 32'h1900);
    step(2);
    rq.delete();
    window(25);
    for (int t = 1; t <= 26; t++)
      if (t == 13) tap(1'b0, 1'b0, 1'b0);
      else tap(1'b1, t == 1, t == 26);
    step(8);
    check("b2b_count", rq.size(), 32'd2);
    check("b2b_res0", {16'b0, rq.size() > 0 ? rq[0] : 16'hxxxx}, 32'h1900);
    check("b2b_res1", {16'b0, rq.size() > 1 ? rq[1] : 16'hxxxx}, 32'h1900);
    cur_state = SIDLE;
    nv0 = nv;
    window(3);
    step(8);
    check("idle_ignored", nv - nv0, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mac_array_acc.md
Name: mac_array_acc

Overview:
- Consumes the lane vector produced by the input line buffer (`input_buf`, MAC_NUM 16-bit lanes) one kernel tap per cycle.
- Multiplies lanes by weights and accumulates across the taps of a kernel window or FC input chunk, then emits bias-added, rescaled, saturated 16-bit results.
- Conv states: lane-wise accumulation with a broadcast weight.
- FC states: lane-wise products reduced through an adder tree into one dot-product result.
- Sits between the input buffer and the pooling/writeback stage.

Parameters:
- MAC_NUM, 120, lane count; equals `MAC_NUM` in def_header.vh.
- DATA_W, 16, signed fixed-point operand width.
- FRAC_W, 8, fractional bits of operands and outputs.
- ACC_W, 40, signed accumulator width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cur_state  in  4  layer state (`SCONV_1`, `SCONV_2`, `SFC_1`, `SFC_2`, `SFC_3`)
- in_valid  in  1  tap valid
- first_tap  in  1  first tap of a window/chunk sequence; qualified by in_valid
- last_tap  in  1  last tap; qualified by in_valid
- input_buf  in  MAC_NUM*DATA_W  lane operands
- weight_bcast  in  DATA_W  conv broadcast weight
- weight_vec  in  MAC_NUM*DATA_W  FC per-lane weights
- bias  in  DATA_W  added once per result
- out_valid  out  1  one-cycle result strobe
- out_data  out  MAC_NUM*DATA_W  conv lane results
- fc_out  out  DATA_W  FC dot-product result

Behaviour:
- Reset (sync, active-high): all pipeline registers, accumulators, out_valid, out_data and fc_out go to 0. Reset mid-accumulation discards partial sums; the next result needs a new first_tap.
- Mode is sampled from cur_state on each accepted first_tap and held until the result emits.
  - SCONV_1: conv mode, 112 active lanes.
  - SCONV_2: conv mode, 100 active lanes.
  - SFC_1: FC mode, 120 active lanes.
  - SFC_2, SFC_3: FC mode, 84 active lanes.
  - Any other state: in_valid ignored.
- Inactive lanes: operands forced to 0, so out_data lanes are 0 and those lanes contribute nothing to the tree.
- Stage P (products): registered signed DATA_W x DATA_W products, 2*DATA_W bits, 2*FRAC_W fractional bits.
  - Conv uses weight_bcast.
  - FC uses the matching weight_vec lane.
- Conv path:
  - Stage A: acc[i] = product on first_tap, else acc[i] + product; sign-extended to ACC_W.
  - Stage O on last_tap: out = sat16((acc + (bias <<< FRAC_W)) >>> FRAC_W), arithmetic shift (truncate toward -inf).
  - Latency: out_valid asserts 3 cycles after the in_valid & last_tap cycle.
- FC path:
  - Stage T: registered sum of all active-lane products (adder tree).
  - Stage A accumulates the tree sum across chunks.
  - Stage O as for conv, result on fc_out.
  - Latency: 4 cycles.
  - out_data is held during FC; fc_out is held during conv.
- Saturation: clamp to [0x8000, 0x7FFF].
- Edge cases:
  - first_tap & last_tap in the same cycle: single-tap result.
  - first_tap before a pending last_tap: restarts the accumulation; the old partial sum is dropped.
  - in_valid low: that slot is a bubble; accumulators hold.
  - Back-to-back windows (last_tap immediately followed by first_tap) run at full throughput with no bubble.
- out_valid is high exactly one cycle per result; out_data/fc_out hold their value until the next result.

Optional Feature:
- Macro MAC_RELU_EN.
- Defined: stage O applies ReLU after saturation; negative results become 0x0000.
- Undefined: signed saturated result passes through unchanged. Latency is identical in both builds.

Decomposition:
- Shared package/header (def_header.vh): state encodings, MAC_NUM, a new FRAC_W define, active-lane-count constants per state (112/100/120/84).
- One sub-module: mac_adder_tree. Parameterised, MAC_NUM inputs of 2*DATA_W bits, one output register, used only on the FC path.

Test Plan:
- SCONV_1, 25 taps (first on tap 1, last on tap 25), all lanes 0x0100, weight_bcast 0x0100, bias 0 -> out_valid 3 cycles after last tap; lanes 0..111 = 0x1900; lanes 112..119 = 0.
- SCONV_2, 25 taps of 0x7FFF x 0x7FFF -> lanes 0..99 = 0x7FFF (saturated); lanes 100..119 = 0.
- SFC_2, one chunk with first=last, 84 lanes 0x0100, weight_vec lanes 0x0080, bias 0x0100 -> fc_out = 0x2B00 (42+1), 4-cycle latency.
- Conv, single tap, input 0xFF00 (-1.0), weight 0x0100, bias 0 -> 0x0000 with MAC_RELU_EN, 0xFF00 without.
- Reset asserted at tap 10 of 25, then a fresh 25-tap window of the first scenario -> no out_valid from the aborted window; then a clean 0x1900.
- Back-to-back windows with an in_valid bubble inside the second window -> two results, each 0x1900, the bubble causing no corruption.
